// File: rtl/integ_dump.sv
// integ_dump: integrate-and-dump decimator; sums N_eff signed samples per block, emits registered sum with a one-cycle strobe.
module integ_dump #(
  parameter int bits_in   = 16,
  parameter int bits_out  = 24,
  parameter int RATE_BITS = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       enable,
  input  logic [RATE_BITS-1:0]       rate,
  input  logic signed [bits_in-1:0]  in,
  input  logic                       strobe_in,
  output logic signed [bits_out-1:0] out,
  output logic                       strobe_out
);
  typedef enum logic {IDLE, ACCUM} state_t;
  state_t                     state_q, state_d;
  logic signed [bits_out-1:0] acc_q, acc_d, out_q, out_d, sum;
  logic [RATE_BITS-1:0]       count_q, count_d, n_eff_q, n_eff_d, n_cur, count_inc;
  logic                       strobe_q, strobe_d, last;
  always_comb begin
    // The block that starts this cycle already uses the live rate
    n_cur     = (state_q == IDLE) ? rate : n_eff_q;
    count_inc = count_q + RATE_BITS'(1);
    sum       = acc_q + bits_out'(in);
    last      = count_inc == ((n_cur == '0) ? RATE_BITS'(1) : n_cur);
    state_d   = enable ? ACCUM : IDLE;
    acc_d     = acc_q;
    count_d   = count_q;
    n_eff_d   = (state_q == IDLE && enable) ? rate : n_eff_q;
    out_d     = out_q;
    strobe_d  = 1'b0;
    if (!enable) begin
      acc_d   = '0;
      count_d = '0;
    end else if (strobe_in) begin
      if (last) begin
        out_d    = sum;
        strobe_d = 1'b1;
        acc_d    = '0;
        count_d  = '0;
        n_eff_d  = rate;
      end else begin
        acc_d   = sum;
        count_d = count_inc;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      count_q  <= '0;
      n_eff_q  <= '0;
      out_q    <= '0;
      strobe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      count_q  <= count_d;
      n_eff_q  <= n_eff_d;
      out_q    <= out_d;
      strobe_q <= strobe_d;
    end
  end
  assign out        = out_q;
  assign strobe_out = strobe_q;
endmodule

// File: tb/tb_integ_dump.sv
// tb_integ_dump: directed and random stimulus against a queue-based block-sum reference model.
`timescale 1ns/1ps
module tb_integ_dump;
  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               enable = 1'b0;
  logic [7:0]         rate = '0;
  logic signed [15:0] in = '0;
  logic               strobe_in = 1'b0;
  logic signed [23:0] out;
  logic               strobe_out;
  int                 checks = 0;
  int                 passed = 0;
  logic               active = 1'b0;
  int                 n_blk = 1;
  int                 samples[$];
  logic [23:0]        exp_out = '0;
  logic               exp_strobe = 1'b0;

  integ_dump dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .rate(rate),
    .in(in), .strobe_in(strobe_in), .out(out), .strobe_out(strobe_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] expv);
    checks++;
    assert (obs === expv) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
  endtask

  task automatic step(input logic en, input logic [7:0] r, input logic s, input logic signed [15:0] x, input string tag);
    longint total;
    enable = en; rate = r; strobe_in = s; in = x;
    @(posedge clk); #1;
    exp_strobe = 1'b0;
    if (!en) begin
      active = 1'b0;
      samples.delete();
    end else begin
      if (!active) begin
        active = 1'b1;
        n_blk = (r == 0) ? 1 : int'(r);
      end
      if (s) begin
        samples.push_back(int'(x));
        if (samples.size() == n_blk) begin
          total = 0;
          foreach (samples[i]) total += samples[i];
          exp_out = total[23:0];
          exp_strobe = 1'b1;
          samples.delete();
          n_blk = (r == 0) ? 1 : int'(r);
        end
      end
    end
    chk({tag, ".strobe"}, {23'd0, strobe_out}, {23'd0, exp_strobe});
    chk({tag, ".out"}, out, exp_out);
  endtask

  task automatic pulse_reset(input string tag);
    #2 rst_n = 1'b0;
    #1;
    active = 1'b0;
    samples.delete();
    exp_out = '0;
    exp_strobe = 1'b0;
    chk({tag, ".out"}, out, 24'd0);
    chk({tag, ".strobe"}, {23'd0, strobe_out}, 24'd0);
    @(posedge clk); #3 rst_n = 1'b1;
  endtask

  initial begin
    #3;
    chk("rst.out", out, 24'd0);
    chk("rst.strobe", {23'd0, strobe_out}, 24'd0);
    @(posedge clk); #3 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_hold.out", out, 24'd0);
    // Strobes while disabled are ignored
    for (int i = 0; i < 3; i++) step(1'b0, 8'd1, 1'b1, 16'sd77, "idle");
    // Steady +100 at rate 4
    for (int i = 0; i < 12; i++) step(1'b1, 8'd4, 1'b1, 16'sd100, "r4");
    chk("r4.value", out, 24'd400);
    step(1'b0, 8'd3, 1'b0, 16'sd0, "flush");
    step(1'b1, 8'd3, 1'b1, -16'sd5, "r3");
    step(1'b1, 8'd3, 1'b0, 16'sd9, "r3");
    step(1'b1, 8'd3, 1'b1, 16'sd2, "r3");
    step(1'b1, 8'd3, 1'b0, 16'sd9, "r3");
    step(1'b1, 8'd3, 1'b0, 16'sd9, "r3");
    step(1'b1, 8'd3, 1'b1, -16'sd1, "r3");
    chk("r3.value", out, 24'hFFFFFC);
    for (int i = 0; i < 3; i++) step(1'b1, 8'd3, 1'b0, 16'sd0, "r3.quiet");
    step(1'b0, 8'd0, 1'b0, 16'sd0, "flush");
    step(1'b1, 8'd0, 1'b1, 16'sh7FFF, "r0");
    chk("r0.max", out, 24'd32767);
    step(1'b1, 8'd0, 1'b1, -16'sd32768, "r0");
    chk("r0.min", out, 24'hFF8000);
    step(1'b1, 8'd0, 1'b0, 16'sd5, "r0.gap");
    step(1'b0, 8'd255, 1'b0, 16'sd0, "flush");
    for (int i = 0; i < 255; i++) step(1'b1, 8'd255, 1'b1, 16'sh7FFF, "r255");
    chk("r255.value", out, 24'd8355585);
    step(1'b0, 8'd4, 1'b0, 16'sd0, "flush");
    step(1'b1, 8'd4, 1'b1, 16'sd1000, "abort");
    step(1'b1, 8'd4, 1'b1, 16'sd1000, "abort");
    step(1'b0, 8'd4, 1'b1, 16'sd1000, "abort.off");
    for (int i = 1; i <= 4; i++) step(1'b1, 8'd4, 1'b1, 16'(i), "post");
    chk("post.value", out, 24'd10);
    step(1'b1, 8'd4, 1'b1, 16'sd50, "mid");
    step(1'b1, 8'd4, 1'b1, 16'sd50, "mid");
    pulse_reset("arst");
    step(1'b1, 8'd4, 1'b1, 16'sd3, "arst.blk");
    step(1'b1, 8'd4, 1'b1, 16'sd3, "arst.blk");
    step(1'b1, 8'd2, 1'b1, 16'sd3, "ratechg");
    step(1'b1, 8'd2, 1'b1, 16'sd3, "ratechg");
    chk("ratechg.value", out, 24'd12);
    for (int i = 0; i < 4; i++) step(1'b1, 8'd2, 1'b1, 16'sd7, "r2");
    for (int i = 0; i < 400; i++) begin
      logic [7:0] r;
      r = (i % 37 < 20) ? 8'(i % 5) : 8'($urandom_range(0, 9));
      step(($urandom_range(0, 19) != 0), r, 1'($urandom), 16'($urandom), "rand");
      if (i == 200) pulse_reset("rand.rst");
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/integ_dump.md
INTEG_DUMP -- requirements
Module: integ_dump

Interface
REQ-001 SHALL have parameter bits_in, default 16: signed input sample width.
REQ-002 SHALL have parameter bits_out, default 24: signed accumulator/output width; feeds the downstream clipping register.
REQ-003 SHALL have parameter RATE_BITS, default 8: width of the decimation-rate port.
REQ-004 SHALL have port clk  input  1: single clock; all logic on the rising edge.
REQ-005 SHALL have port rst_n  input  1: asynchronous, active-low reset.
REQ-006 SHALL have port enable  input  1: high = run; low = flush to IDLE.
REQ-007 SHALL have port rate  input  RATE_BITS: number of input samples per dump (N).
REQ-008 SHALL have port in  input  bits_in: two's-complement sample.
REQ-009 SHALL have port strobe_in  input  1: in is valid this cycle.
REQ-010 SHALL have port out  output  bits_out: registered dumped sum.
REQ-011 SHALL have port strobe_out  output  1: one-cycle pulse, out newly valid.

Function
REQ-012 SHALL implement two states: IDLE (enable low) and ACCUM (enable high).
REQ-013 IDLE: acc = 0, count = 0, strobe_out = 0, out holds last value, strobe_in ignored.
REQ-014 IDLE->ACCUM on the first cycle enable is high; a strobe_in in that same cycle is accumulated.
REQ-015 ACCUM->IDLE on the first cycle enable is low; the partial sum is discarded and no strobe_out is issued.
REQ-016 SHALL latch rate into N_eff at the IDLE->ACCUM transition and after every dump; rate changes mid-block SHALL NOT affect the block in progress.
REQ-017 rate = 0 SHALL be treated as N_eff = 1: pass-through with one-cycle latency.
REQ-018 Each strobe_in in ACCUM SHALL sign-extend in to bits_out and add it to acc.
REQ-019 Each strobe_in in ACCUM SHALL increment count.
REQ-020 Cycles without strobe_in SHALL leave acc and count unchanged.
REQ-021 Dump: on the strobe_in carrying sample number N_eff, the block SHALL:
  - on the next edge, load out = acc + in;
  - pulse strobe_out for exactly one cycle;
  - load acc = 0 and count = 0;
  - relatch N_eff.
REQ-022 Latency: strobe_out is high in the cycle after the final strobe_in; back-to-back strobe_in SHALL be accepted with no lost sample.
REQ-023 Arithmetic SHALL wrap modulo 2^bits_out, with no saturation; saturation is the downstream stage's job.
REQ-024 bits_out >= bits_in + RATE_BITS guarantees no wrap.
REQ-025 strobe_out SHALL NOT assert at any time other than a dump.

Reset
REQ-026 rst_n low SHALL immediately, without a clock, force:
  - state = IDLE;
  - acc = 0, count = 0, N_eff = 0;
  - out = 0, strobe_out = 0.
REQ-027 Reset mid-block SHALL discard the partial sum; the first block after rst_n rises SHALL start counting from sample 1.
REQ-028 Reset deassertion SHALL take effect on the next clk edge; no output toggles before that edge.

Verification
REQ-029 rate=4, enable=1, in=+100 strobed every cycle -> strobe_out every 4th cycle, out=400, 1 cycle after the 4th strobe.
REQ-030 rate=3, samples -5, +2, -1 with idle gaps between strobes -> single strobe_out, out=-4 (0xFFFFFC), no extra pulses.
REQ-031 rate=0, in=0x7FFF and 0x8000 on consecutive strobes -> out=32767 then -32768, one strobe_out per input.
REQ-032 rate=255, in=0x7FFF x255 (bits_out=24) -> out=8355585, no wrap; bits_out=20 build -> value modulo 2^20.
REQ-033 rate=4, enable dropped after 2 samples, then re-raised -> no strobe_out; the next dump sums only the 4 post-enable samples.
REQ-034 rst_n pulsed low between clock edges mid-block -> out=0 and strobe_out=0 at once; a rate change to 2 mid-block applies only to the following block.
